// File: rtl/mult4_seq_ctrl.sv
// mult4_seq_ctrl
// 4x4 unsigned multiplier built around one shared, external 2x2 multiplier.
// Each operand is split into two 2-bit slices, and the four partial products
// (LL, LH, HL, HH) are formed one per clock, then shifted and summed.
//
// CALC always starts at step LL, and that first cycle is the one in which the
// latched operands become visible. When SKIP_ZERO is set, a step whose A slice
// or B slice is zero contributes nothing, and the step walker jumps straight
// past it. As a result:
//   - all four steps run    -> out_valid 4 edges after the accept edge
//   - only HH runs          -> out_valid 2 edges after the accept edge
//   - no step runs          -> out_valid 1 edge after the accept edge, P = 0
module mult4_seq_ctrl #(
  parameter int unsigned SKIP_ZERO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  output logic [1:0]  mul_a,
  output logic [1:0]  mul_b,
  input  logic [3:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  P,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  // Control state and datapath registers.
  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  step_r;
  logic [1:0]  step_nxt_s;
  logic [3:0]  a_r;
  logic [3:0]  a_nxt_s;
  logic [3:0]  b_r;
  logic [3:0]  b_nxt_s;
  logic [7:0]  acc_r;
  logic [7:0]  acc_nxt_s;
  logic [15:0] op_count_r;
  logic [15:0] op_count_nxt_s;

  // Registered versions of the status outputs.
  logic        out_valid_r;
  logic        busy_r;
  logic [7:0]  p_r;

  // Handshake decode and step bookkeeping.
  logic        in_ready_s;
  logic        accept_s;
  logic        xfer_s;
  logic [3:0]  step_en_s;
  logic [2:0]  next_step_s;

  // Returns {a_slice, b_slice} for the given partial-product step.
  function automatic logic [3:0] operand_slices(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [1:0] step
  );
    logic [3:0] res;
    case (step)
      STEP_LL: res = {a[1:0], b[1:0]};
      STEP_LH: res = {a[1:0], b[3:2]};
      STEP_HL: res = {a[3:2], b[1:0]};
      STEP_HH: res = {a[3:2], b[3:2]};
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  // Places a 2x2 partial product at its weight within the 8-bit result.
  function automatic logic [7:0] weighted_product(
    input logic [3:0] p,
    input logic [1:0] step
  );
    logic [7:0] res;
    case (step)
      STEP_LL: res = {4'd0, p};
      STEP_LH: res = {2'd0, p, 2'd0};
      STEP_HL: res = {2'd0, p, 2'd0};
      STEP_HH: res = {p, 4'd0};
      default: res = 8'd0;
    endcase
    return res;
  endfunction

  // Marks which steps contribute; with skipping, a zero slice kills the step.
  function automatic logic [3:0] step_enables(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] en;
    logic [3:0] sl;
    en = 4'd0;
    for (int k = 0; k < 4; k++) begin
      sl = operand_slices(a, b, 2'(k));
      if (SKIP_ZERO == 0) begin
        en[2'(k)] = 1'b1;
      end else begin
        en[2'(k)] = (sl[3:2] != 2'd0) && (sl[1:0] != 2'd0);
      end
    end
    return en;
  endfunction

  // Returns {found, step} for the lowest enabled step strictly after cur.
  function automatic logic [2:0] next_enabled(
    input logic [3:0] en,
    input logic [1:0] cur
  );
    logic [2:0] res;
    res = 3'd0;
    for (int k = 3; k >= 1; k--) begin
      if ((k > int'(cur)) && en[2'(k)]) begin
        res = {1'b1, 2'(k)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign in_ready_s  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign xfer_s      = (state_r == ST_DONE) && out_ready;
  assign step_en_s   = step_enables(a_r, b_r);
  assign next_step_s = next_enabled(step_en_s, step_r);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign P         = p_r;
  assign op_count  = op_count_r;

  // Drive the shared multiplier from the latched slices only while computing.
  always_comb begin
    mul_a = 2'd0;
    mul_b = 2'd0;
    if (state_r == ST_CALC) begin
      {mul_a, mul_b} = operand_slices(a_r, b_r, step_r);
    end else begin
      mul_a = 2'd0;
      mul_b = 2'd0;
    end
  end

  // Next-state, step walk, operand latch, accumulation and transfer counting.
  always_comb begin
    state_nxt_s    = state_r;
    step_nxt_s     = step_r;
    a_nxt_s        = a_r;
    b_nxt_s        = b_r;
    acc_nxt_s      = acc_r;
    op_count_nxt_s = op_count_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          a_nxt_s     = A;
          b_nxt_s     = B;
          acc_nxt_s   = 8'd0;
          step_nxt_s  = STEP_LL;
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_CALC: begin
        // A and B are deliberately ignored here; only the latched copies count.
        if (step_en_s[step_r]) begin
          acc_nxt_s = acc_r + weighted_product(mul_p, step_r);
        end else begin
          acc_nxt_s = acc_r;
        end
        if (next_step_s[2]) begin
          step_nxt_s  = next_step_s[1:0];
          state_nxt_s = ST_CALC;
        end else begin
          step_nxt_s  = STEP_LL;
          state_nxt_s = ST_DONE;
        end
      end

      ST_DONE: begin
        if (xfer_s) begin
          op_count_nxt_s = op_count_r + 16'd1;
          if (accept_s) begin
            a_nxt_s     = A;
            b_nxt_s     = B;
            acc_nxt_s   = 8'd0;
            step_nxt_s  = STEP_LL;
            state_nxt_s = ST_CALC;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DONE;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = STEP_LL;
      end
    endcase
  end

  // State, operand and accumulator registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      step_r     <= STEP_LL;
      a_r        <= 4'd0;
      b_r        <= 4'd0;
      acc_r      <= 8'd0;
      op_count_r <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      step_r     <= step_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      acc_r      <= acc_nxt_s;
      op_count_r <= op_count_nxt_s;
    end
  end

  // Status outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      p_r         <= 8'd0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      p_r         <= (state_nxt_s == ST_DONE) ? acc_nxt_s : 8'd0;
    end
  end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed bench for mult4_seq_ctrl: one instance without skipping (u0) and one
// with SKIP_ZERO=1 (u1), each paired with a behavioural 2x2 multiplier.
module tb_mult4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv0, ir0, ov0, or0, busy0;
  logic [3:0]  a0, b0, mp0;
  logic [1:0]  ma0, mb0;
  logic [7:0]  p0;
  logic [15:0] cnt0;

  logic        iv1, ir1, ov1, or1, busy1;
  logic [3:0]  a1, b1, mp1;
  logic [1:0]  ma1, mb1;
  logic [7:0]  p1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mp0 = {2'b00, ma0} * {2'b00, mb0};
  assign mp1 = {2'b00, ma1} * {2'b00, mb1};

  mult4_seq_ctrl #(.SKIP_ZERO(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .out_valid(ov0), .out_ready(or0),
    .P(p0), .busy(busy0), .op_count(cnt0)
  );

  mult4_seq_ctrl #(.SKIP_ZERO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .out_valid(ov1), .out_ready(or1),
    .P(p1), .busy(busy1), .op_count(cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv0 = 1'b0; a0 = 4'd0; b0 = 4'd0; or0 = 1'b0;
    iv1 = 1'b0; a1 = 4'd0; b1 = 4'd0; or1 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid",  32'(ov0),   32'd0);
    check("rst_busy",   32'(busy0), 32'd0);
    check("rst_mul_a",  32'(ma0),   32'd0);
    check("rst_mul_b",  32'(mb0),   32'd0);
    check("rst_p",      32'(p0),    32'd0);
    check("rst_count",  32'(cnt0),  32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready0", 32'(ir0),   32'd1);
    check("rst_ready1", 32'(ir1),   32'd1);

    // Scenario 1: 0xF * 0xF, all four steps use slices 3/3
    a0 = 4'hF; b0 = 4'hF; iv0 = 1'b1; or0 = 1'b1;
    tick();
    iv0 = 1'b0; a0 = 4'h0; b0 = 4'h0;
    for (int s = 0; s < 4; s++) begin
      check("s1_mul_a", 32'(ma0), 32'd3);
      check("s1_mul_b", 32'(mb0), 32'd3);
      check("s1_no_valid", 32'(ov0), 32'd0);
      tick();
    end
    check("s1_valid", 32'(ov0), 32'd1);
    check("s1_p",     32'(p0),  32'hE1);
    tick();
    check("s1_count", 32'(cnt0), 32'd1);
    check("s1_idle_valid", 32'(ov0), 32'd0);
    check("s1_idle_p",     32'(p0),  32'd0);
    check("s1_idle_busy",  32'(busy0), 32'd0);

    // Scenario 2: all 256 pairs back to back; next operands change mid-CALC
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    iv0 = 1'b1; or0 = 1'b1; a0 = 4'd0; b0 = 4'd0;
    tick();
    for (int i = 0; i < 256; i++) begin
      if (i < 255) begin
        a0 = 4'((i + 1) / 16);
        b0 = 4'((i + 1) % 16);
      end else begin
        iv0 = 1'b0;
      end
      tick(); tick(); tick(); tick();
      check("s2_valid", 32'(ov0), 32'd1);
      check("s2_p",     32'(p0),  32'((i / 16) * (i % 16)));
      if (i < 255) begin
        check("s2_ready", 32'(ir0), 32'd1);
      end else begin
        check("s2_last_ready", 32'(ir0), 32'd1);
      end
      tick();
    end
    check("s2_count", 32'(cnt0), 32'h100);
    check("s2_idle",  32'(busy0), 32'd0);

    // Scenario 3: backpressure holds 0x36 for 10 cycles
    a0 = 4'h6; b0 = 4'h9; iv0 = 1'b1; or0 = 1'b0;
    tick();
    a0 = 4'hF; b0 = 4'hF;
    tick(); tick(); tick(); tick();
    for (int c = 0; c < 10; c++) begin
      check("s3_valid", 32'(ov0), 32'd1);
      check("s3_p",     32'(p0),  32'h36);
      check("s3_ready", 32'(ir0), 32'd0);
      tick();
    end
    iv0 = 1'b0; or0 = 1'b1;
    #1;
    check("s3_ready_release", 32'(ir0), 32'd1);
    tick();
    check("s3_count", 32'(cnt0), 32'h101);
    check("s3_after_valid", 32'(ov0), 32'd0);
    tick();
    check("s3_count_once", 32'(cnt0), 32'h101);

    // Scenario 4: SKIP_ZERO=1, HH only, then everything skipped
    a1 = 4'h4; b1 = 4'h8; iv1 = 1'b1; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    check("s4_e0_valid", 32'(ov1),   32'd0);
    check("s4_e0_busy",  32'(busy1), 32'd1);
    tick();
    check("s4_e1_valid", 32'(ov1), 32'd0);
    check("s4_hh_mul_a", 32'(ma1), 32'd1);
    check("s4_hh_mul_b", 32'(mb1), 32'd2);
    tick();
    check("s4_e2_valid", 32'(ov1), 32'd1);
    check("s4_e2_p",     32'(p1),  32'h20);
    tick();
    check("s4_count1", 32'(cnt1), 32'd1);
    a1 = 4'h0; b1 = 4'hF; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    check("s4_z_e0_valid", 32'(ov1), 32'd0);
    tick();
    check("s4_z_e1_valid", 32'(ov1), 32'd1);
    check("s4_z_e1_p",     32'(p1),  32'd0);
    tick();
    check("s4_count2", 32'(cnt1), 32'd2);

    // Scenario 5: reset during step 2 of 0xB * 0x7
    a0 = 4'hB; b0 = 4'h7; iv0 = 1'b1; or0 = 1'b1;
    tick();
    iv0 = 1'b0;
    tick(); tick();
    check("s5_hl_mul_a", 32'(ma0), 32'd2);
    check("s5_hl_mul_b", 32'(mb0), 32'd3);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", 32'(ov0),   32'd0);
    check("s5_rst_busy",  32'(busy0), 32'd0);
    check("s5_rst_mul_a", 32'(ma0),   32'd0);
    check("s5_rst_count", 32'(cnt0),  32'd0);
    check("s5_rst_count1", 32'(cnt1), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("s5_ready", 32'(ir0), 32'd1);
    a0 = 4'h3; b0 = 4'h5; iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    tick(); tick(); tick(); tick();
    check("s5_valid", 32'(ov0), 32'd1);
    check("s5_p",     32'(p0),  32'h0F);
    tick();
    check("s5_count", 32'(cnt0), 32'd1);

    // Scenario 6: op_count wraps after 65536 transfers (all-skip operands)
    a1 = 4'h0; b1 = 4'h0; iv1 = 1'b1; or1 = 1'b1;
    tick();
    for (int n = 1; n <= 65535; n++) begin
      tick();
      tick();
    end
    check("s6_count_ffff", 32'(cnt1), 32'hFFFF);
    iv1 = 1'b0;
    tick();
    check("s6_last_valid", 32'(ov1), 32'd1);
    tick();
    check("s6_wrap", 32'(cnt1), 32'd0);
    check("s6_idle_valid", 32'(ov1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
